// File: rtl/id_insn_queue.sv
// id_insn_queue: DEPTH-entry FIFO of {En, PC, Insn} decoupling fetch from decode.
// The head entry is read from storage at the read pointer and gated by QValid.
// Flush empties the queue in one cycle. Overflow is sticky until reset.
module id_insn_queue #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Flush,
  input  logic              Push,
  input  logic              IFEn,
  input  logic [ADDR_W-1:0] IFPC,
  input  logic [DATA_W-1:0] IFInsn,
  output logic              PushReady,
  input  logic              Pop,
  output logic              QValid,
  output logic              QEn,
  output logic [ADDR_W-1:0] QPC,
  output logic [DATA_W-1:0] QInsn,
  output logic [CNT_W-1:0]  Count,
  output logic              Overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic              en_mem   [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] insn_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic push_ok;
  logic pop_ok;

  // Handshake qualification; PushReady looks at occupancy only, never at Pop.
  always_comb begin
    PushReady = (count_q < CNT_W'(DEPTH));
    QValid    = (count_q != '0);
    push_ok   = Push && PushReady && !Flush;
    pop_ok    = Pop && QValid && !Flush;
  end

  // Entry storage; contents survive flush/reset but are hidden behind QValid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      en_mem[wr_ptr]   <= IFEn;
      pc_mem[wr_ptr]   <= IFPC;
      insn_mem[wr_ptr] <= IFInsn;
    end
  end

  // Pointers and occupancy; flush and reset both return to an empty queue.
  always_ff @(posedge clk) begin
    if (reset || Flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CNT_W'(1);
    end
  end

  // Sticky overflow: any push offered while full, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)                  overflow_q <= 1'b0;
    else if (Push && !PushReady) overflow_q <= 1'b1;
  end

  // Head presentation; everything reads as zero while the queue is empty.
  always_comb begin
    QEn   = 1'b0;
    QPC   = '0;
    QInsn = '0;
    if (QValid) begin
      QEn   = en_mem[rd_ptr];
      QPC   = pc_mem[rd_ptr];
      QInsn = insn_mem[rd_ptr];
    end
  end

  assign Count    = count_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_id_insn_queue.sv
// Directed bench for id_insn_queue with DEPTH = 4.
module tb_id_insn_queue;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset, Flush, Push, IFEn, Pop;
  logic [ADDR_W-1:0] IFPC;
  logic [DATA_W-1:0] IFInsn;
  logic              PushReady, QValid, QEn, Overflow;
  logic [ADDR_W-1:0] QPC;
  logic [DATA_W-1:0] QInsn;
  logic [CNT_W-1:0]  Count;

  int checks = 0;
  int errors = 0;

  id_insn_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Flush(Flush), .Push(Push), .IFEn(IFEn),
    .IFPC(IFPC), .IFInsn(IFInsn), .PushReady(PushReady), .Pop(Pop),
    .QValid(QValid), .QEn(QEn), .QPC(QPC), .QInsn(QInsn), .Count(Count),
    .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; Flush = 0; Push = 0; Pop = 0; IFEn = 0; IFPC = '0; IFInsn = '0;
  endtask

  task automatic push_one(input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] insn, input logic en);
    idle(); Push = 1; IFPC = pc; IFInsn = insn; IFEn = en;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle(); reset = 1;
    step();
    idle();
    checks++; if (PushReady !== 1'b1) begin errors++; $display("FAIL reset_pushready got %0h exp 1", PushReady); end
    checks++; if (QValid !== 1'b0) begin errors++; $display("FAIL reset_qvalid got %0h exp 0", QValid); end
    checks++; if (QEn !== 1'b0) begin errors++; $display("FAIL reset_qen got %0h exp 0", QEn); end
    checks++; if (QPC !== '0) begin errors++; $display("FAIL reset_qpc got %0h exp 0", QPC); end
    checks++; if (QInsn !== '0) begin errors++; $display("FAIL reset_qinsn got %0h exp 0", QInsn); end
    checks++; if (Count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", Count); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0h exp 0", Overflow); end
  endtask

  task automatic test_first_push();
    push_one(30'h100, 32'hDEADBEEF, 1'b1);
    checks++; if (QValid !== 1'b1) begin errors++; $display("FAIL first_qvalid got %0h exp 1", QValid); end
    checks++; if (QEn !== 1'b1) begin errors++; $display("FAIL first_qen got %0h exp 1", QEn); end
    checks++; if (QPC !== 30'h100) begin errors++; $display("FAIL first_qpc got %0h exp 100", QPC); end
    checks++; if (QInsn !== 32'hDEADBEEF) begin errors++; $display("FAIL first_qinsn got %0h exp deadbeef", QInsn); end
    checks++; if (Count !== 3'd1) begin errors++; $display("FAIL first_count got %0d exp 1", Count); end
    idle(); Pop = 1; step(); idle();
    checks++; if (QValid !== 1'b0) begin errors++; $display("FAIL first_drain_qvalid got %0h exp 0", QValid); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 4; i++) push_one(30'h10 + 30'(i), 32'hA000_0000 + 32'(i), 1'b1);
    checks++; if (Count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", Count); end
    checks++; if (PushReady !== 1'b0) begin errors++; $display("FAIL fill_pushready got %0h exp 0", PushReady); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow_pre got %0h exp 0", Overflow); end
    push_one(30'h14, 32'hBAD, 1'b1);
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %0h exp 1", Overflow); end
    checks++; if (Count !== 3'd4) begin errors++; $display("FAIL fill_count_after_ovf got %0d exp 4", Count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (QPC !== 30'h10 + 30'(i)) begin errors++; $display("FAIL drain_qpc[%0d] got %0h exp %0h", i, QPC, 30'h10 + 30'(i)); end
      checks++; if (QInsn !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL drain_qinsn[%0d] got %0h exp %0h", i, QInsn, 32'hA000_0000 + 32'(i)); end
      idle(); Pop = 1; step(); idle();
    end
    checks++; if (QValid !== 1'b0) begin errors++; $display("FAIL drain_qvalid got %0h exp 0", QValid); end
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", Count); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) push_one(30'h20 + 30'(i), 32'(i), 1'b1);
    idle(); Push = 1; Pop = 1; IFPC = 30'h24; IFEn = 1; step(); idle();
    checks++; if (Count !== 3'd3) begin errors++; $display("FAIL fullpp_count got %0d exp 3", Count); end
    checks++; if (QPC !== 30'h21) begin errors++; $display("FAIL fullpp_qpc got %0h exp 21", QPC); end
    checks++; if (PushReady !== 1'b1) begin errors++; $display("FAIL fullpp_pushready got %0h exp 1", PushReady); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (QPC !== 30'h20 + 30'(i)) begin errors++; $display("FAIL fullpp_order[%0d] got %0h exp %0h", i, QPC, 30'h20 + 30'(i)); end
      idle(); Pop = 1; step(); idle();
    end
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL fullpp_empty got %0d exp 0", Count); end
  endtask

  task automatic test_stream();
    push_one(30'h300, 32'h3000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      checks++; if (QPC !== 30'h300 + 30'(i)) begin errors++; $display("FAIL stream_qpc[%0d] got %0h exp %0h", i, QPC, 30'h300 + 30'(i)); end
      checks++; if (Count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d exp 1", i, Count); end
      idle(); Push = 1; Pop = 1; IFEn = 1;
      IFPC = 30'h301 + 30'(i); IFInsn = 32'h3001 + 32'(i);
      step(); idle();
    end
    checks++; if (QPC !== 30'h314) begin errors++; $display("FAIL stream_end_qpc got %0h exp 314", QPC); end
    checks++; if (QInsn !== 32'h3014) begin errors++; $display("FAIL stream_end_qinsn got %0h exp 3014", QInsn); end
  endtask

  task automatic test_flush();
    push_one(30'h51, 32'h0, 1'b1);
    push_one(30'h52, 32'h0, 1'b1);
    checks++; if (Count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", Count); end
    idle(); Flush = 1; Push = 1; IFPC = 30'h99; IFEn = 1; step(); idle();
    checks++; if (QValid !== 1'b0) begin errors++; $display("FAIL flush_qvalid got %0h exp 0", QValid); end
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", Count); end
    checks++; if (PushReady !== 1'b1) begin errors++; $display("FAIL flush_pushready got %0h exp 1", PushReady); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL flush_overflow got %0h exp 1", Overflow); end
    checks++; if (QEn !== 1'b0) begin errors++; $display("FAIL flush_qen got %0h exp 0", QEn); end
    push_one(30'h200, 32'h2222, 1'b1);
    checks++; if (QPC !== 30'h200) begin errors++; $display("FAIL flush_next_qpc got %0h exp 200", QPC); end
    checks++; if (Count !== 3'd1) begin errors++; $display("FAIL flush_next_count got %0d exp 1", Count); end
    idle(); Pop = 1; step(); idle();
  endtask

  task automatic test_bubble();
    push_one(30'h40, 32'h4444, 1'b0);
    checks++; if (QValid !== 1'b1) begin errors++; $display("FAIL bubble_qvalid got %0h exp 1", QValid); end
    checks++; if (QEn !== 1'b0) begin errors++; $display("FAIL bubble_qen got %0h exp 0", QEn); end
    checks++; if (QPC !== 30'h40) begin errors++; $display("FAIL bubble_qpc got %0h exp 40", QPC); end
    idle(); Pop = 1; step();
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL bubble_pop_count got %0d exp 0", Count); end
    step(); idle();
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL empty_pop_count got %0d exp 0", Count); end
    idle(); Push = 1; Pop = 1; IFPC = 30'h41; IFEn = 1; step(); idle();
    checks++; if (Count !== 3'd1) begin errors++; $display("FAIL empty_pushpop_count got %0d exp 1", Count); end
    checks++; if (QPC !== 30'h41) begin errors++; $display("FAIL empty_pushpop_qpc got %0h exp 41", QPC); end
  endtask

  task automatic test_reset_mid();
    push_one(30'h42, 32'h1, 1'b1);
    checks++; if (Count !== 3'd2) begin errors++; $display("FAIL midrst_pre_count got %0d exp 2", Count); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL midrst_pre_overflow got %0h exp 1", Overflow); end
    idle(); reset = 1; Push = 1; Pop = 1; IFPC = 30'h77; IFEn = 1; step(); idle();
    checks++; if (PushReady !== 1'b1) begin errors++; $display("FAIL midrst_pushready got %0h exp 1", PushReady); end
    checks++; if (QValid !== 1'b0) begin errors++; $display("FAIL midrst_qvalid got %0h exp 0", QValid); end
    checks++; if (QEn !== 1'b0) begin errors++; $display("FAIL midrst_qen got %0h exp 0", QEn); end
    checks++; if (QPC !== '0) begin errors++; $display("FAIL midrst_qpc got %0h exp 0", QPC); end
    checks++; if (QInsn !== '0) begin errors++; $display("FAIL midrst_qinsn got %0h exp 0", QInsn); end
    checks++; if (Count !== '0) begin errors++; $display("FAIL midrst_count got %0d exp 0", Count); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow got %0h exp 0", Overflow); end
  endtask

  initial begin
    idle();
    test_reset();
    test_first_push();
    test_fill_overflow();
    test_full_push_pop();
    test_stream();
    test_flush();
    test_bubble();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_insn_queue.md
# id_insn_queue

Parametrised decoupling queue between the IF and ID stages. Replaces the single IF/ID pipeline latch with a DEPTH-entry FIFO of {PC, instruction, enable}, so a decode stall no longer back-pressures fetch immediately. Flush discards all buffered instructions in one cycle. The head entry is presented to the decoder as registered outputs.

## Interface
Parameters:
- ADDR_W, 30, width of the word-address PC field
- DATA_W, 32, instruction width
- DEPTH, 4, number of entries; power of two, >= 2
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- Flush  in  1  discard all entries; the same-cycle push is also discarded
- Push  in  1  IF offers an entry this cycle
- IFEn  in  1  enable bit of the offered entry (0 = bubble, stored as-is)
- IFPC  in  ADDR_W  PC of the offered entry
- IFInsn  in  DATA_W  instruction of the offered entry
- PushReady  out  1  queue accepts a push this cycle; equals (Count < DEPTH)
- Pop  in  1  ID consumes the head entry this cycle (driven by the decoder as !Stall)
- QValid  out  1  head entry is valid; equals (Count != 0)
- QEn  out  1  head entry enable
- QPC  out  ADDR_W  head entry PC
- QInsn  out  DATA_W  head entry instruction
- Count  out  CNT_W  current occupancy, 0..DEPTH
- Overflow  out  1  sticky flag: Push was asserted while PushReady = 0

## Operation
- Storage: DEPTH entries of {En, PC, Insn}.
- Pointers: write pointer and read pointer, each $clog2(DEPTH) bits, wrapping naturally modulo DEPTH. Count is held separately; full and empty are never derived from pointer equality.
- Accepted push: Push && PushReady && !Flush. Writes the entry at the write pointer, then increments the write pointer.
- Effective pop: Pop && QValid && !Flush. Increments the read pointer. Pop while empty is ignored and does not underflow Count.
- Count update: +1 on accepted push only; -1 on effective pop only; unchanged when both or neither occur.
- PushReady depends on Count only, never on Pop, so there is no combinational path from Pop to PushReady.
  - When full, a same-cycle Push is refused even if Pop = 1.
  - A refused push sets Overflow. Overflow clears only on reset; Flush does not clear it.
- Head outputs: QEn/QPC/QInsn are the entry at the read pointer, driven from registers or storage, never combinationally from IF inputs.
  - When empty, the head outputs are 0.
  - QEn is forced to 0 whenever QValid = 0.
- Flush:
  - Next state: read pointer = write pointer = 0, Count = 0.
  - Storage contents are not cleared but are never exposed, because QEn is gated by QValid.
  - Flush has priority over Push and Pop.
- Reset: same effect as Flush, plus Overflow = 0.
- Reset values of outputs: PushReady = 1, QValid = 0, QEn = 0, QPC = 0, QInsn = 0, Count = 0, Overflow = 0.

## Timing
- Push-to-visibility latency is 1 cycle.
  - An entry pushed into an empty queue at edge N appears on QValid/QPC/QInsn after edge N; there is no same-cycle bypass.
- Pop-to-next-head latency is 1 cycle: after the edge that pops, the head outputs show the next entry.
- Simultaneous push and pop at 0 < Count < DEPTH: Count unchanged; entry order preserved.
- Simultaneous push and pop at Count = 0: pop ignored, push accepted, Count becomes 1.
- Simultaneous push and pop at Count = DEPTH: push refused (Overflow set), pop taken, Count becomes DEPTH-1.
- Flush and reset take effect at the next edge. In the following cycle QValid = 0 and PushReady = 1.
- Throughput: with Push = Pop = 1 every cycle and 0 < Count < DEPTH, one entry per cycle.

## Test plan
- Reset then idle: all outputs at reset values; Push = 1 for PC = 0x100, Insn = 0xDEADBEEF, IFEn = 1 -> next cycle QValid = 1, QPC = 0x100, QInsn = 0xDEADBEEF, Count = 1.
- Fill with DEPTH = 4 pushes (PCs 0x10..0x13) and Pop = 0 -> Count = 4, PushReady = 0. Fifth push -> Overflow = 1, Count stays 4. Then pop 4 times -> QPC steps 0x10, 0x11, 0x12, 0x13, then QValid = 0.
- Streaming: Push = Pop = 1 for 20 cycles on incrementing PCs, starting from Count = 1 -> Count stays 1, pointers wrap at least 4 times, QPC sequence is strictly incrementing with no loss or duplication.
- Flush with Count = 3 and a simultaneous Push -> next cycle QValid = 0, Count = 0, PushReady = 1, Overflow unchanged. A subsequent push of PC 0x200 is the next head.
- Bubble entry: push IFEn = 0, PC = 0x40 -> at the head, QValid = 1, QEn = 0, QPC = 0x40. Pop on an empty queue -> Count stays 0.
- Reset asserted mid-stream at Count = 2 with Overflow = 1 -> next cycle all outputs return to reset values, including Overflow = 0.
